uart_multibyte_tx: RTL and testbench



---
 rtl/uart_multibyte_tx.sv | 141 ++++++++++++++
 tb/tb_uart_multibyte_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_multibyte_tx.sv
// rtl/uart_multibyte_tx.sv - 8N1 UART transmitter sending a latched multi-byte buffer back-to-back
module uart_multibyte_tx #(
  parameter int DELAY_FRAMES  = 234,
  parameter int MEMORY_LENGTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [MEMORY_LENGTH*8-1:0] data,
  output logic                       uart_tx,
  input  logic                       dataReady,
  output logic                       busy,
  output logic                       done
);

  localparam int CNT_W = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
  localparam int IDX_W = (MEMORY_LENGTH > 1) ? $clog2(MEMORY_LENGTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [2:0]                 bit_q, bit_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [MEMORY_LENGTH*8-1:0] buf_q, buf_d;
  logic                       tx_q, tx_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [7:0]                 cur_byte;
  logic                       period_end;

  // Select the byte currently being serialised from the latched buffer
  always_comb begin
    cur_byte = '0;
    for (int k = 0; k < MEMORY_LENGTH; k++) begin
      if (idx_q == IDX_W'(k)) cur_byte = buf_q[k*8 +: 8];
    end
  end

  assign period_end = (cnt_q == CNT_W'(DELAY_FRAMES - 1));

  // Next-state logic; outputs are computed for the next state so they leave as flops
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (dataReady) begin
          buf_d   = data;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (period_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
          tx_d    = cur_byte[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (period_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (period_end) begin
          cnt_d = '0;
          if (idx_q != IDX_W'(MEMORY_LENGTH - 1)) begin
            // Next byte starts immediately, no idle gap between frames
            idx_d   = idx_q + IDX_W'(1);
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      idx_q   <= '0;
      buf_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign uart_tx = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_multibyte_tx.sv
// tb/tb_uart_multibyte_tx.sv - directed self-checking bench for uart_multibyte_tx
module tb_uart_multibyte_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data0 = 16'h0000;
  logic        rdy0 = 1'b0;
  logic        tx0, busy0, done0;
  logic [7:0]  data1 = 8'h00;
  logic        rdy1 = 1'b0;
  logic        tx1, busy1, done1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_multibyte_tx #(.DELAY_FRAMES(8), .MEMORY_LENGTH(2)) u_dut (
    .clk(clk), .rst(rst), .data(data0), .uart_tx(tx0),
    .dataReady(rdy0), .busy(busy0), .done(done0)
  );

  uart_multibyte_tx #(.DELAY_FRAMES(1), .MEMORY_LENGTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .data(data1), .uart_tx(tx1),
    .dataReady(rdy1), .busy(busy1), .done(done1)
  );

  // Line level s clocks after the trigger edge for an 8-clock-per-bit, 2-byte transfer
  function automatic logic exp_tx(input logic [15:0] d, input int s);
    int f, p;
    f = s / 80;
    p = (s % 80) / 8;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return d[f*8 + p - 1];
  endfunction

  task automatic test_reset();
    logic [2:0] obs;
    rst = 1'b1;
    #1;
    n_total++;
    if ({tx0, busy0, done0, tx1, busy1, done1} !== 6'b100100)
      $display("FAIL reset_state got %b exp 100100", {tx0, busy0, done0, tx1, busy1, done1});
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    data0 = 16'hAAAA;
    rdy0  = 1'b1;
    for (int s = 0; s < 12; s++) begin
      @(posedge clk); #1;
      if (s == 0) rdy0 = 1'b0;
    end
    n_total++;
    if ({tx0, busy0} !== 2'b01) $display("FAIL reset_midframe_pre got %b exp 01", {tx0, busy0});
    else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    obs = {tx0, busy0, done0};
    if (obs !== 3'b100) $display("FAIL reset_async got %b exp 100", obs);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if ({tx0, busy0, done0} !== 3'b100) $display("FAIL reset_hold got %b exp 100", {tx0, busy0, done0});
    else n_pass++;
    rst = 1'b0;
    for (int s = 0; s < 20; s++) begin
      @(posedge clk); #1;
      n_total++;
      if ({tx0, busy0, done0} !== 3'b100)
        $display("FAIL reset_release s=%0d got %b exp 100", s, {tx0, busy0, done0});
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp;
    data0 = 16'hAAAA;
    rdy0  = 1'b1;
    for (int s = 0; s < 162; s++) begin
      @(posedge clk); #1;
      if (s < 160) exp = {exp_tx(16'hAAAA, s), 2'b10};
      else if (s == 160) exp = 3'b101;
      else exp = 3'b100;
      n_total++;
      if ({tx0, busy0, done0} !== exp)
        $display("FAIL basic s=%0d got %b exp %b", s, {tx0, busy0, done0}, exp);
      else n_pass++;
      if (s == 3) rdy0 = 1'b0;
    end
  endtask

  task automatic test_byte_order();
    logic [2:0] exp;
    data0 = 16'h0F01;
    rdy0  = 1'b1;
    for (int s = 0; s < 162; s++) begin
      @(posedge clk); #1;
      if (s < 160) exp = {exp_tx(16'h0F01, s), 2'b10};
      else if (s == 160) exp = 3'b101;
      else exp = 3'b100;
      n_total++;
      if ({tx0, busy0, done0} !== exp)
        $display("FAIL byte_order s=%0d got %b exp %b", s, {tx0, busy0, done0}, exp);
      else n_pass++;
      if (s == 0) rdy0 = 1'b0;
    end
  endtask

  task automatic test_latch();
    logic [2:0] exp;
    data0 = 16'h3CA5;
    rdy0  = 1'b1;
    for (int s = 0; s < 182; s++) begin
      @(posedge clk); #1;
      if (s < 160) exp = {exp_tx(16'h3CA5, s), 2'b10};
      else if (s == 160) exp = 3'b101;
      else exp = 3'b100;
      n_total++;
      if ({tx0, busy0, done0} !== exp)
        $display("FAIL latch s=%0d got %b exp %b", s, {tx0, busy0, done0}, exp);
      else n_pass++;
      if (s == 0) rdy0 = 1'b0;
      if (s == 20) begin
        data0 = 16'hFFFF;
        rdy0  = 1'b1;
      end
      if (s == 23) rdy0 = 1'b0;
    end
  endtask

  task automatic test_retrigger();
    logic [2:0] exp;
    logic       seen;
    data0 = 16'h5A0F;
    rdy0  = 1'b1;
    for (int s = 0; s < 175; s++) begin
      @(posedge clk); #1;
      if (s < 160) exp = {exp_tx(16'h5A0F, s), 2'b10};
      else if (s == 160) exp = 3'b101;
      else exp = {exp_tx(16'h5A0F, s - 161), 2'b10};
      n_total++;
      if ({tx0, busy0, done0} !== exp)
        $display("FAIL retrigger s=%0d got %b exp %b", s, {tx0, busy0, done0}, exp);
      else n_pass++;
    end
    rdy0 = 1'b0;
    seen = 1'b0;
    for (int s = 0; s < 200 && !seen; s++) begin
      @(posedge clk); #1;
      if (done0) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b1) $display("FAIL retrigger_end got done=%b exp 1 within 200 clocks", seen);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({tx0, busy0, done0} !== 3'b100)
      $display("FAIL retrigger_idle got %b exp 100", {tx0, busy0, done0});
    else n_pass++;
  endtask

  task automatic test_fast();
    logic [9:0] seq;
    logic [2:0] exp;
    seq   = 10'b1010101010;
    data1 = 8'h55;
    rdy1  = 1'b1;
    for (int s = 0; s < 12; s++) begin
      @(posedge clk); #1;
      if (s < 10) exp = {seq[s], 2'b10};
      else if (s == 10) exp = 3'b101;
      else exp = 3'b100;
      n_total++;
      if ({tx1, busy1, done1} !== exp)
        $display("FAIL fast s=%0d got %b exp %b", s, {tx1, busy1, done1}, exp);
      else n_pass++;
      if (s == 0) rdy1 = 1'b0;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_byte_order();
    test_latch();
    test_retrigger();
    test_fast();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish exp finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
